// File: rtl/heap_pkg.sv
// Shared defaults, FSM state type and address helper for the heap array reader.
package heap_pkg;

    localparam int MEMORY_ELEMENT_WIDTH = 12;
    localparam int N_AREA               = 10;
    localparam int N_ARRAYS             = 2;
    localparam int N_HEAP               = 20;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        READ,
        WAIT,
        SEND,
        FINISH
    } state_e;

    // Arrays sit back to back on the heap, one fixed-size area each.
    function automatic int heap_addr(input int arr, input int idx, input int k, input int n_area);
        return arr * n_area + idx + k;
    endfunction

endpackage

// File: rtl/heap_array_reader_if.sv
// Heap read port plus element stream of the heap array reader.
interface heap_array_reader_if #(
    parameter int W = heap_pkg::MEMORY_ELEMENT_WIDTH
);

    logic         memRdEn;
    logic [W-1:0] memRdAddr;
    logic [W-1:0] memRdData;
    logic         outValid;
    logic         outLast;
    logic [W-1:0] outData;
    logic         outReady;

    modport master (
        output memRdEn, memRdAddr, outValid, outLast, outData,
        input  memRdData, outReady
    );

    modport slave (
        input  memRdEn, memRdAddr, outValid, outLast, outData,
        output memRdData, outReady
    );

endinterface

// File: rtl/heap_out_stage.sv
// Output register of the element stream: holds one element until the consumer takes it.
module heap_out_stage
    import heap_pkg::*;
#(
    parameter int W = MEMORY_ELEMENT_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] data_in,
    input  logic         last_in,
    input  logic         ready,
    output logic         valid,
    output logic         last,
    output logic [W-1:0] data,
    output logic         fire
);

    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic [W-1:0] data_q, data_d;

    assign fire  = valid_q & ready;
    assign valid = valid_q;
    assign last  = last_q;
    assign data  = data_q;

    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            last_d  = last_in;
            data_d  = data_in;
        end else if (fire) begin
            // data is left in place; only the qualifiers drop
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/heap_array_reader.sv
// Streams a range of elements of one heap-resident array, one heap read per element.
// Optional macro HEAP_ARRAY_READER_BOUNDS_CHECK_EN also rejects ranges past the array's current size.
module heap_array_reader
    import heap_pkg::*;
#(
    parameter int MemoryElementWidth = MEMORY_ELEMENT_WIDTH,
    parameter int NArea              = N_AREA,
    parameter int NArrays            = N_ARRAYS,
    parameter int NHeap              = N_HEAP
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic [MemoryElementWidth-1:0] array,
    input  logic [MemoryElementWidth-1:0] index,
    input  logic [MemoryElementWidth-1:0] count,
    input  logic [MemoryElementWidth-1:0] size,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    heap_array_reader_if.master           bus
);

    localparam int W = MemoryElementWidth;

    state_e       state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         error_q, error_d;
    logic         rd_en_q, rd_en_d;
    logic [W-1:0] rd_addr_q, rd_addr_d;
    logic [W-1:0] k_q, k_d;
    logic [W-1:0] array_q, array_d;
    logic [W-1:0] index_q, index_d;
    logic [W-1:0] count_q, count_d;

    logic [W:0]   end_sum;
    logic         bad_req;
    logic         is_last;
    logic         load;
    logic         fire;

    // Parameter sets whose arrays overrun the heap read address 0 instead of wrapping.
    function automatic logic [W-1:0] addr_of(input logic [W-1:0] arr, input logic [W-1:0] idx,
                                             input logic [W-1:0] k);
        int full;
        full = heap_addr(int'(arr), int'(idx), int'(k), NArea);
        return (full < NHeap) ? W'(full) : '0;
    endfunction

`ifdef HEAP_ARRAY_READER_BOUNDS_CHECK_EN
    logic [W-1:0] size_q, size_d;
`else
    logic unused_size;
    assign unused_size = ^size;
`endif

    // One bit wider so a huge index+count cannot wrap below the limit.
    assign end_sum = {1'b0, index_q} + {1'b0, count_q};
    assign is_last = (k_q == count_q - 1'b1);

    always_comb begin
        bad_req = (array_q >= W'(NArrays)) || (end_sum > (W+1)'(NArea));
`ifdef HEAP_ARRAY_READER_BOUNDS_CHECK_EN
        if (end_sum > {1'b0, size_q}) bad_req = 1'b1;
`endif
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        k_d       = k_q;
        array_d   = array_q;
        index_d   = index_q;
        count_d   = count_q;
`ifdef HEAP_ARRAY_READER_BOUNDS_CHECK_EN
        size_d    = size_q;
`endif
        load      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    array_d = array;
                    index_d = index;
                    count_d = count;
`ifdef HEAP_ARRAY_READER_BOUNDS_CHECK_EN
                    size_d  = size;
`endif
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (bad_req) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = FINISH;
                end else if (count_q == '0) begin
                    done_d  = 1'b1;
                    state_d = FINISH;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_of(array_q, index_q, '0);
                    state_d   = READ;
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (fire) begin
                    if (is_last) begin
                        done_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        k_d       = k_q + 1'b1;
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_of(array_q, index_q, k_q + 1'b1);
                        state_d   = READ;
                    end
                end
            end
            FINISH: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            k_q       <= '0;
            array_q   <= '0;
            index_q   <= '0;
            count_q   <= '0;
`ifdef HEAP_ARRAY_READER_BOUNDS_CHECK_EN
            size_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            k_q       <= k_d;
            array_q   <= array_d;
            index_q   <= index_d;
            count_q   <= count_d;
`ifdef HEAP_ARRAY_READER_BOUNDS_CHECK_EN
            size_q    <= size_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign bus.memRdEn   = rd_en_q;
    assign bus.memRdAddr = rd_addr_q;

    heap_out_stage #(.W(W)) u_out (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .data_in (bus.memRdData),
        .last_in (is_last),
        .ready   (bus.outReady),
        .valid   (bus.outValid),
        .last    (bus.outLast),
        .data    (bus.outData),
        .fire    (fire)
    );

endmodule

// File: doc/heap_array_reader.md
HEAP_ARRAY_READER -- requirements
Module: heap_array_reader

Interface
REQ-001 SHALL have parameter MemoryElementWidth, default 12, giving element, address and length width.
REQ-002 SHALL have parameter NArea, default 10, giving elements per array area on the heap.
REQ-003 SHALL have parameter NArrays, default 2, giving the maximum number of arrays.
REQ-004 SHALL have parameter NHeap, default 20, giving heap memory depth.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have ports start (input, 1) plus array, index, count, size (inputs, MemoryElementWidth each): the read request, meaning array number, first element, element count and current array length; all sampled when start is high in IDLE.
REQ-008 SHALL have port busy, output, 1 bit: high when not IDLE.
REQ-009 SHALL have ports done and error, outputs, 1 bit each: done is a one-cycle completion pulse; error qualifies done.
REQ-010 SHALL have ports memRdEn (output, 1), memRdAddr (output, MemoryElementWidth) and memRdData (input, MemoryElementWidth): the heap read port, whose data is valid one cycle after memRdEn.
REQ-011 SHALL have ports outValid, outLast, outData (outputs; 1, 1 and MemoryElementWidth bits) and outReady (input, 1): the element stream.

Function
REQ-012 SHALL implement states IDLE, CHECK, READ, WAIT, SEND and FINISH.
REQ-013 IDLE with start=1 SHALL register the request and go to CHECK; start while busy SHALL be ignored.
REQ-014 CHECK SHALL raise error when array >= NArrays or index+count > NArea, then go to FINISH; otherwise count=0 SHALL go to FINISH and anything else SHALL go to READ.
REQ-015 index+count SHALL be computed one bit wider than MemoryElementWidth, so overflow cannot wrap and pass the check.
REQ-016 READ SHALL assert memRdEn for exactly one cycle with memRdAddr = array*NArea + index + k, where k is the element number from 0; it SHALL then go to WAIT.
REQ-017 WAIT SHALL capture memRdData into the output register and go to SEND.
REQ-018 SEND SHALL hold outValid=1 with outData stable until outReady=1 is sampled.
REQ-019 In SEND, outLast SHALL be high exactly when k = count-1.
REQ-020 On a handshake in SEND, k SHALL increment; the state SHALL go to READ, or to FINISH after the last element.
REQ-021 Timing: start sampled at edge E0, then CHECK; memRdEn in the cycle after E1; outValid first high after E3; sustained rate is 1 element per 3 cycles with outReady=1.
REQ-022 FINISH SHALL pulse done for one cycle (error with it if set) and return to IDLE; a new start SHALL be accepted the cycle after.
REQ-023 memRdEn SHALL never be asserted for a rejected or zero-count request.

Reset
REQ-024 reset=0 at a rising edge SHALL force IDLE and drive busy, done, error, memRdEn, outValid, outLast, outData, memRdAddr and k to 0.
REQ-025 reset mid-transfer SHALL abandon the transfer with no done pulse; the cycle after reset releases SHALL accept start.

Configuration
REQ-026 With HEAP_ARRAY_READER_BOUNDS_CHECK_EN defined, CHECK SHALL also raise error when index+count > size.
REQ-027 Without HEAP_ARRAY_READER_BOUNDS_CHECK_EN, size SHALL be ignored; only the REQ-014 checks apply.

Structure
REQ-028 Package heap_pkg SHALL hold MemoryElementWidth, NArea, NArrays and NHeap defaults, plus the state enum type.
REQ-029 Output register and handshake SHALL live in one sub-module, heap_out_stage; address generation and the FSM SHALL stay in heap_array_reader.

Verification
Common setup: heap preloaded with array 0 = 0..9 and array 1 = 100..109 (addresses 10..19).
REQ-030 array=0, index=4, count=3, size=10, outReady=1 -> memRdAddr 4,5,6; outData 4,5,6 with outLast on 6; one done pulse; error=0.
REQ-031 array=1, index=2, count=3, outReady alternating 0/1 -> outData 102,103,104, each held stable while stalled; memRdAddr 12,13,14.
REQ-032 count=0 -> done after the CHECK cycle; no memRdEn, no outValid. array=2 -> done with error, no reads. index=8, count=3 -> error.
REQ-033 index=4, count=3, size=5 -> with macro: done with error, no reads; without macro: outData 4,5,6.
REQ-034 reset low for one cycle after the first element handshake -> busy, outValid and memRdEn 0 next cycle, no done; a following request array=0, index=0, count=1 returns 0 with outLast.
